// File: rtl/gshare_bp.sv
// rtl/gshare_bp.sv - gshare direction predictor, PC xor speculative GHR; GSHARE_BYPASS_EN forwards same-cycle updates to lookups
module gshare_bp #(
  parameter int unsigned VLEN            = 64,
  parameter int unsigned INSTR_PER_FETCH = 2,
  parameter int unsigned NR_ENTRIES      = 1024,
  parameter int unsigned HIST_BITS       = 9,
  parameter int unsigned CTR_BITS        = 2,
  localparam int unsigned ROW_BITS       = $clog2(NR_ENTRIES / INSTR_PER_FETCH)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_bp_i,
  input  logic                       debug_mode_i,
  input  logic [VLEN-1:0]            vpc_i,
  input  logic                       lookup_valid_i,
  input  logic                       spec_push_i,
  input  logic                       spec_taken_i,
  input  logic                       upd_valid_i,
  input  logic [VLEN-1:0]            upd_pc_i,
  input  logic                       upd_taken_i,
  input  logic                       upd_mispredict_i,
  input  logic [ROW_BITS-1:0]        upd_index_i,
  input  logic [HIST_BITS-1:0]       upd_hist_i,
  output logic                       ready_o,
  output logic [INSTR_PER_FETCH-1:0] pred_valid_o,
  output logic [INSTR_PER_FETCH-1:0] pred_taken_o,
  output logic [ROW_BITS-1:0]        pred_index_o,
  output logic [HIST_BITS-1:0]       pred_hist_o
);

  localparam int unsigned NR_ROWS   = NR_ENTRIES / INSTR_PER_FETCH;
  localparam int unsigned SLOT_BITS = $clog2(INSTR_PER_FETCH);
  localparam int unsigned OFFSET    = SLOT_BITS + 1;
  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
  localparam logic [CTR_BITS-1:0] CTR_INIT = {1'b0, {(CTR_BITS-1){1'b1}}};

  typedef enum logic {INIT, RUN} state_e;

  state_e                     state_q, state_d;
  logic [ROW_BITS-1:0]        init_row_q;
  logic [HIST_BITS-1:0]       ghr_q, ghr_d;
  logic [CTR_BITS-1:0]        ctr_q [NR_ROWS][INSTR_PER_FETCH];

  logic                       running, upd_en;
  logic [ROW_BITS-1:0]        lookup_row;
  logic [SLOT_BITS-1:0]       lookup_slot, upd_slot;
  logic [CTR_BITS-1:0]        upd_cur, upd_nxt;
  logic [INSTR_PER_FETCH-1:0] slot_mask, rd_taken, fwd_hit;
  logic                       unused_bits;

  function automatic logic [HIST_BITS-1:0] shift_in(input logic [HIST_BITS-1:0] h, input logic b);
    return (h << 1) | HIST_BITS'(b);
  endfunction

  assign running     = (state_q == RUN);
  assign ready_o     = running;
  assign lookup_row  = vpc_i[OFFSET+ROW_BITS-1:OFFSET] ^ ROW_BITS'(ghr_q);
  assign lookup_slot = vpc_i[OFFSET-1:1];
  assign upd_slot    = upd_pc_i[OFFSET-1:1];
  assign upd_en      = running && upd_valid_i && !debug_mode_i && !flush_bp_i;
  assign unused_bits = ^{vpc_i[VLEN-1:OFFSET+ROW_BITS], vpc_i[0], upd_pc_i[VLEN-1:OFFSET], upd_pc_i[0]};

  always_comb begin
    state_d = state_q;
    case (state_q)
      INIT:    if (init_row_q == ROW_BITS'(NR_ROWS - 1)) state_d = RUN;
      default: state_d = state_q;
    endcase
    if (flush_bp_i) state_d = INIT;
  end

  // Restore from resolved metadata takes priority over a same-cycle speculative push.
  always_comb begin
    ghr_d = ghr_q;
    if (running && !debug_mode_i) begin
      if (upd_valid_i && upd_mispredict_i) ghr_d = shift_in(upd_hist_i, upd_taken_i);
      else if (spec_push_i)                ghr_d = shift_in(ghr_q, spec_taken_i);
    end
  end

  always_comb begin
    upd_cur = ctr_q[upd_index_i][upd_slot];
    upd_nxt = upd_cur;
    if (upd_taken_i) begin
      if (upd_cur != CTR_MAX) upd_nxt = upd_cur + 1'b1;
    end else begin
      if (upd_cur != '0) upd_nxt = upd_cur - 1'b1;
    end
  end

`ifdef GSHARE_BYPASS_EN
  always_comb begin
    fwd_hit = '0;
    for (int s = 0; s < INSTR_PER_FETCH; s++)
      fwd_hit[s] = upd_en && (upd_index_i == lookup_row) && (upd_slot == SLOT_BITS'(s));
  end
`else
  assign fwd_hit = '0;
`endif

  always_comb begin
    slot_mask = '0;
    rd_taken  = '0;
    for (int s = 0; s < INSTR_PER_FETCH; s++) begin
      slot_mask[s] = (SLOT_BITS'(s) >= lookup_slot);
      rd_taken[s]  = fwd_hit[s] ? upd_nxt[CTR_BITS-1]
                                : ctr_q[lookup_row][SLOT_BITS'(s)][CTR_BITS-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= INIT;
      init_row_q <= '0;
      ghr_q      <= '0;
    end else begin
      state_q <= state_d;
      if (flush_bp_i) begin
        init_row_q <= '0;
        ghr_q      <= '0;
      end else begin
        if (state_q == INIT) init_row_q <= init_row_q + 1'b1;
        ghr_q <= ghr_d;
      end
    end
  end

  // Counter array has no reset; the INIT sweep establishes its contents.
  always_ff @(posedge clk_i) begin
    if (state_q == INIT) begin
      for (int s = 0; s < INSTR_PER_FETCH; s++) ctr_q[init_row_q][SLOT_BITS'(s)] <= CTR_INIT;
    end else if (upd_en) begin
      ctr_q[upd_index_i][upd_slot] <= upd_nxt;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pred_valid_o <= '0;
      pred_taken_o <= '0;
      pred_index_o <= '0;
      pred_hist_o  <= '0;
    end else begin
      pred_valid_o <= '0;
      if (running && lookup_valid_i) begin
        pred_valid_o <= slot_mask;
        pred_taken_o <= rd_taken;
        pred_index_o <= lookup_row;
        pred_hist_o  <= ghr_q;
      end
    end
  end

endmodule

// File: tb/tb_gshare_bp.sv
// tb/tb_gshare_bp.sv - directed self-checking bench for gshare_bp
module tb_gshare_bp;
  localparam int VLEN = 64;

  logic            clk = 1'b0;
  logic            rst, flush, debug, lookup_valid, spec_push, spec_taken;
  logic            upd_valid, upd_taken, upd_mispredict;
  logic [VLEN-1:0] vpc, upd_pc;
  logic [8:0]      upd_index, upd_hist;
  logic            ready;
  logic [1:0]      pred_valid, pred_taken;
  logic [8:0]      pred_index, pred_hist;

  int checks = 0;
  int errors = 0;
  int cnt;
  logic exp_fwd;

  always #5 clk = ~clk;

  gshare_bp dut (
    .clk_i(clk), .rst_i(rst), .flush_bp_i(flush), .debug_mode_i(debug),
    .vpc_i(vpc), .lookup_valid_i(lookup_valid),
    .spec_push_i(spec_push), .spec_taken_i(spec_taken),
    .upd_valid_i(upd_valid), .upd_pc_i(upd_pc), .upd_taken_i(upd_taken),
    .upd_mispredict_i(upd_mispredict), .upd_index_i(upd_index), .upd_hist_i(upd_hist),
    .ready_o(ready), .pred_valid_o(pred_valid), .pred_taken_o(pred_taken),
    .pred_index_o(pred_index), .pred_hist_o(pred_hist)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic lookup(input logic [VLEN-1:0] pc);
    vpc = pc;
    lookup_valid = 1'b1;
    step();
    lookup_valid = 1'b0;
  endtask

  task automatic update(input logic [8:0] idx, input logic [VLEN-1:0] pc, input logic tk, input int n);
    upd_index = idx;
    upd_pc    = pc;
    upd_taken = tk;
    upd_valid = 1'b1;
    repeat (n) step();
    upd_valid = 1'b0;
  endtask

  task automatic wait_ready(output int c);
    c = 0;
    while (!ready && c < 2000) begin
      c++;
      step();
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; debug = 1'b0; lookup_valid = 1'b0;
    spec_push = 1'b0; spec_taken = 1'b0; upd_valid = 1'b0; upd_taken = 1'b0;
    upd_mispredict = 1'b0; vpc = '0; upd_pc = '0; upd_index = '0; upd_hist = '0;
    repeat (2) step();
    check("reset_ready", ready, 0);
    check("reset_pred", {pred_valid, pred_taken, pred_index, pred_hist}, 0);

    rst = 1'b0;
    wait_ready(cnt);
    check("init_cycles", cnt, 512);
    check("ready_after_init", ready, 1);

    for (int r = 0; r < 512; r++) begin
      lookup(64'(r) << 2);
      check("sweep_row", {pred_valid, pred_taken, pred_index}, {2'b11, 2'b00, 9'(r)});
    end
    step();
    check("no_lookup_valid", pred_valid, 0);
    lookup(64'h1002);
    check("slot1_mask", pred_valid, 2'b10);

    // Saturating counter at row 0 slot 0
    update(9'd0, 64'h1000, 1'b1, 4);
    lookup(64'h1000);
    check("sat_hi_valid", pred_valid, 2'b11);
    check("sat_hi_taken", pred_taken, 2'b01);
    update(9'd0, 64'h1000, 1'b0, 1);
    lookup(64'h1000);
    check("sat_10_taken", pred_taken[0], 1);
    update(9'd0, 64'h1000, 1'b0, 3);
    lookup(64'h1000);
    check("sat_00_taken", pred_taken[0], 0);
    update(9'd0, 64'h1000, 1'b0, 1);
    lookup(64'h1000);
    check("sat_lo_hold", pred_taken[0], 0);
    update(9'd0, 64'h1000, 1'b1, 1);
    lookup(64'h1000);
    check("sat_lo_to_01", pred_taken, 2'b00);
    update(9'd0, 64'h1000, 1'b1, 1);
    lookup(64'h1000);
    check("sat_01_to_10", pred_taken, 2'b01);

    spec_push = 1'b1; spec_taken = 1'b1;
    repeat (3) step();
    spec_push = 1'b0;
    lookup(64'h40);
    check("hist_index", pred_index, 9'h017);
    check("hist_ghr", pred_hist, 9'h007);

    spec_push = 1'b1;
    repeat (6) step();
    spec_push = 1'b0;
    lookup(64'h0);
    check("ghr_full", pred_hist, 9'h1FF);

    upd_mispredict = 1'b1; upd_hist = 9'h0A5; spec_push = 1'b1; spec_taken = 1'b1;
    update(9'd5, 64'h0, 1'b0, 1);
    upd_mispredict = 1'b0; spec_push = 1'b0; upd_hist = '0;
    lookup(64'h0);
    check("restore_ghr", pred_hist, 9'h14A);
    check("restore_index", pred_index, 9'h14A);

    debug = 1'b1; upd_mispredict = 1'b1; spec_push = 1'b1;
    update(9'd0, 64'h1000, 1'b0, 2);
    debug = 1'b0; upd_mispredict = 1'b0; spec_push = 1'b0;
    lookup(64'h528);
    check("debug_ghr", pred_hist, 9'h14A);
    check("debug_ctr", {pred_index, pred_taken[0]}, {9'h000, 1'b1});

`ifdef GSHARE_BYPASS_EN
    exp_fwd = 1'b1;
`else
    exp_fwd = 1'b0;
`endif
    vpc = 64'h534; lookup_valid = 1'b1;
    update(9'd7, 64'h0, 1'b1, 1);
    lookup_valid = 1'b0;
    check("collide_index", pred_index, 9'h007);
    check("collide_taken", pred_taken[0], exp_fwd);
    lookup(64'h534);
    check("collide_after", pred_taken[0], 1);

    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_ready_drop", ready, 0);
    wait_ready(cnt);
    check("flush_init_cycles", cnt, 512);
    for (int r = 0; r < 512; r++) begin
      lookup(64'(r) << 2);
      check("flush_sweep", {pred_taken, pred_index, pred_hist}, {2'b00, 9'(r), 9'h000});
    end

    flush = 1'b1;
    step();
    flush = 1'b0;
    repeat (100) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (10) step();
    update(9'd3, 64'h0, 1'b1, 2);
    lookup(64'h0);
    check("init_lookup_ignored", pred_valid, 0);
    wait_ready(cnt);
    check("rst_mid_init_cycles", cnt + 13, 512);
    lookup(64'hC);
    check("init_update_dropped", {pred_index, pred_taken}, {9'h003, 2'b00});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/gshare_bp.md
Name: gshare_bp

Overview:
- Parametrised successor of the global branch predictor (gbp).
- A gshare direction predictor: row index = fetch PC XOR speculative global history register (GHR).
- Tables hold INSTR_PER_FETCH saturating counters per row, with configurable counter width and history length.
- Adds speculative GHR update with mispredict restore, self-clearing init FSM, and flush-triggered re-init. Sits in the frontend beside the BTB.

Parameters:
- VLEN, 64, virtual PC width.
- INSTR_PER_FETCH, 2, predictor slots per fetch row (power of 2).
- NR_ENTRIES, 1024, total counters (power of 2); NR_ROWS = NR_ENTRIES/INSTR_PER_FETCH; ROW_BITS = log2(NR_ROWS).
- HIST_BITS, 9, GHR length (1..ROW_BITS).
- CTR_BITS, 2, saturating counter width (2..4).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- flush_bp_i  in  1  restart table clear.
- debug_mode_i  in  1  suppress table and GHR updates.
- vpc_i  in  VLEN  fetch PC.
- lookup_valid_i  in  1  lookup request this cycle.
- spec_push_i  in  1  frontend predicted a conditional branch; shift GHR.
- spec_taken_i  in  1  predicted direction shifted in.
- upd_valid_i  in  1  resolved conditional branch.
- upd_pc_i  in  VLEN  branch PC.
- upd_taken_i  in  1  resolved direction.
- upd_mispredict_i  in  1  restore GHR.
- upd_index_i  in  ROW_BITS  row index from prediction metadata.
- upd_hist_i  in  HIST_BITS  GHR snapshot from prediction metadata.
- ready_o  out  1  init finished.
- pred_valid_o  out  INSTR_PER_FETCH  per-slot prediction valid.
- pred_taken_o  out  INSTR_PER_FETCH  per-slot counter MSB.
- pred_index_o  out  ROW_BITS  metadata: row used.
- pred_hist_o  out  HIST_BITS  metadata: GHR used.

Behaviour:
- Reset is synchronous and active-high on rst_i; one clock clk_i.
- Reset values: all outputs 0; GHR=0; FSM=INIT; init row counter=0.
- FSM INIT:
  - Writes one row per cycle; every counter in the row = 2^(CTR_BITS-1)-1 (weakly not-taken, 01 for CTR_BITS=2).
  - Lookups are ignored during INIT; ready_o=0.
  - After row NR_ROWS-1 is written, the FSM goes to RUN next cycle and ready_o=1.
- flush_bp_i in any state: FSM goes to INIT, init row counter=0, GHR=0.
- rst_i mid-INIT restarts the clear from row 0.
- Index function:
  - OFFSET = log2(INSTR_PER_FETCH)+1.
  - row = vpc_i[OFFSET+ROW_BITS-1:OFFSET] XOR zero-extended GHR.
  - Slot = vpc_i[OFFSET-1:1].
- Lookup latency is 1 cycle (registered RAM read).
  - lookup_valid_i in RUN at cycle N gives, at N+1: pred_valid_o = per-slot mask of slots at or above the vpc_i slot; pred_taken_o = counter MSB; metadata = row and GHR sampled at N.
  - No lookup gives pred_valid_o=0 at N+1.
- GHR update (RUN only, not in debug):
  - spec_push_i: GHR <= {GHR[HIST_BITS-2:0], spec_taken_i}.
  - upd_valid_i & upd_mispredict_i: GHR <= {upd_hist_i[HIST_BITS-2:0], upd_taken_i}. Restore wins over a same-cycle push.
- Counter update (RUN, upd_valid_i, !debug_mode_i):
  - Read-modify-write of row upd_index_i, slot upd_pc_i[OFFSET-1:1].
  - Counter increments if taken, decrements otherwise; saturates at 0 and 2^CTR_BITS-1.
  - The update completes in the same cycle (separate write port; counters are held in flops/distributed RAM).
- Simultaneous lookup and update to the same row/slot: the lookup returns the pre-update value (read-before-write).
- Updates arriving during INIT are dropped.

Optional Feature:
- Macro GSHARE_BYPASS_EN.
- Defined: an update in cycle N to the same row/slot as a lookup in cycle N forwards the post-update counter to pred_taken_o at N+1.
- Undefined: read-before-write as above.

Test Plan:
- Reset, then observe: rst_i high 2 cycles then low → ready_o=0 for exactly 512 cycles, then 1. A lookup at every row during RUN returns pred_taken_o=00 with CTR_BITS=2.
- Saturation: GHR=0, pc=0x1000 slot0, 4 taken updates → counter 11, next lookup taken=1. Then 1 not-taken → 10, still taken. Then 3 not-taken → 00, a 4th stays at 00.
- History/index: spec_push taken x3 → GHR=0x007. Lookup vpc=0x40 → pred_index_o=0x010^0x007=0x017, pred_hist_o=0x007.
- Mispredict restore: GHR=0x1FF, upd_mispredict with hist=0x0A5, taken=0, plus same-cycle spec_push → GHR=0x14A.
- Flush mid-run: set counters, assert flush_bp_i → ready_o drops next cycle, GHR=0. After 512 cycles all counters read 01.
- Debug and collision: debug_mode_i=1 with updates → counters and GHR unchanged. Same-cycle lookup+update on a counter at 01 with taken → pred_taken_o=0 without the macro, 1 with GSHARE_BYPASS_EN.
